// File: rtl/mc_control_fsm.sv
// Multicycle main control unit for the MIPS-subset datapath: sequences each instruction through
// fetch/decode/execute/memory/writeback, stalls on mem_ready and halts on illegal op or timeout.
module mc_control_fsm #(
  parameter int unsigned WaitLimit = 15,
  parameter int unsigned CntW      = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_done_o,
  output logic       fault_o,
  output logic [1:0] fault_code_o,
  output logic [3:0] state_o
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] FaultIllegal = 2'b01;
  localparam logic [1:0] FaultTimeout = 2'b10;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecute  = 4'd7,
    StRwb      = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StAddiEx   = 4'd11,
    StAddiWb   = 4'd12,
    StHalt     = 4'd15
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              in_wait;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    wait_cnt_d   = '0;
    in_wait      = 1'b0;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        in_wait = 1'b1;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        case (opcode_i)
          OpRtype:    state_d = StExecute;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default: begin
            state_d      = StHalt;
            fault_code_d = FaultIllegal;
          end
        endcase
      end
      StMemAddr: begin
        // Opcode is re-sampled here; anything but lw/sw means it changed under us.
        if (opcode_i == OpLw) begin
          state_d = StMemRead;
        end else if (opcode_i == OpSw) begin
          state_d = StMemWrite;
        end else begin
          state_d      = StHalt;
          fault_code_d = FaultIllegal;
        end
      end
      StMemRead: begin
        in_wait = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWrite: begin
        in_wait = 1'b1;
        if (mem_ready_i) state_d = StFetch;
      end
      StExecute: state_d = StRwb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StRwb, StBranch, StJump, StAddiWb: state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase

    // A ready response in the last tolerated cycle wins over the timeout.
    if (in_wait && !mem_ready_i) begin
      if (wait_cnt_q == CntW'(WaitLimit - 1)) begin
        state_d      = StHalt;
        fault_code_d = FaultTimeout;
      end else begin
        wait_cnt_d = wait_cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 2'b00;
    pc_source_o     = 2'b00;
    instr_done_o    = 1'b0;
    fault_o         = 1'b0;
    fault_code_o    = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: alu_src_b_o = 2'b11;
      StMemAddr, StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      StMemRead: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      StMemWrite: begin
        mem_write_o  = 1'b1;
        i_or_d_o     = 1'b1;
        instr_done_o = mem_ready_i;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
      end
      StExecute: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
      end
      StRwb: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = 2'b01;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
        instr_done_o    = 1'b1;
      end
      StJump: begin
        pc_write_o   = 1'b1;
        pc_source_o  = 2'b10;
        instr_done_o = 1'b1;
      end
      StAddiWb: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StHalt: begin
        fault_o      = 1'b1;
        fault_code_o = fault_code_q;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomised scoreboard bench for mc_control_fsm: instructions are expanded into per-cycle phase
// plans, expected outputs are queued as stimulus is driven and a negedge monitor checks them.
module tb_mc_control_fsm;

  localparam int unsigned WaitLimit = 15;

  localparam logic [3:0] SIdle = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SMemAddr = 4'd3;
  localparam logic [3:0] SMemRead = 4'd4, SMemWb = 4'd5, SMemWrite = 4'd6, SExecute = 4'd7;
  localparam logic [3:0] SRwb = 4'd8, SBranch = 4'd9, SJump = 4'd10, SAddiEx = 4'd11;
  localparam logic [3:0] SAddiWb = 4'd12, SHalt = 4'd15;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, fault;
  logic [1:0] alu_src_b, alu_op, pc_source, fault_code;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control_fsm #(.WaitLimit(WaitLimit), .CntW(4)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .opcode_i       (opcode),
    .mem_ready_i    (mem_ready),
    .pc_write_o     (pc_write),
    .pc_write_cond_o(pc_write_cond),
    .i_or_d_o       (i_or_d),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .ir_write_o     (ir_write),
    .mem_to_reg_o   (mem_to_reg),
    .reg_dst_o      (reg_dst),
    .reg_write_o    (reg_write),
    .alu_src_a_o    (alu_src_a),
    .alu_src_b_o    (alu_src_b),
    .alu_op_o       (alu_op),
    .pc_source_o    (pc_source),
    .instr_done_o   (instr_done),
    .fault_o        (fault),
    .fault_code_o   (fault_code),
    .state_o        (state)
  );

  // One planned cycle: the phase the machine should be in and the inputs driven during it.
  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       rst;
    logic [5:0] op;
    logic [1:0] fc;
    logic       chk;
  } cyc_t;

  typedef struct packed {
    logic        chk;
    logic [3:0]  st;
    logic [23:0] v;
  } exp_t;

  cyc_t       plan[$];
  exp_t       exp_q[$];
  logic [5:0] cur_op;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       finish_req = 1'b0;

  // Control word the datapath needs in each phase of an instruction.
  function automatic logic [23:0] exp_vec(input logic [3:0] st, input logic rdy,
                                          input logic [1:0] fc);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, idn, flt;
    logic [1:0] asb, aop, psrc, fcd;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, idn, flt} = '0;
    {asb, aop, psrc, fcd} = '0;
    case (st)
      SFetch:             begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      SDecode:            asb = 2'b11;
      SMemAddr, SAddiEx:  begin asa = 1; asb = 2'b10; end
      SMemRead:           begin mr = 1; iod = 1; end
      SMemWrite:          begin mw = 1; iod = 1; idn = rdy; end
      SMemWb:             begin rw = 1; m2r = 1; idn = 1; end
      SExecute:           begin asa = 1; aop = 2'b10; end
      SRwb:               begin rw = 1; rd = 1; idn = 1; end
      SBranch:            begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; idn = 1; end
      SJump:              begin pw = 1; psrc = 2'b10; idn = 1; end
      SAddiWb:            begin rw = 1; idn = 1; end
      SHalt:              begin flt = 1; fcd = fc; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, idn, flt, fcd, st};
  endfunction

  task automatic push_cyc(input logic [3:0] st, input logic rdy, input logic rst,
                          input logic [1:0] fc, input logic chk);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.rst = rst; c.op = cur_op; c.fc = fc; c.chk = chk;
    plan.push_back(c);
  endtask

  task automatic push_any(input logic [3:0] st, input logic [1:0] fc);
    push_cyc(st, 1'($urandom_range(0, 1)), 1'b0, fc, 1'b1);
  endtask

  // Reset asserted during the last planned cycle and n-1 further cycles.
  task automatic add_reset(input int n);
    plan[plan.size() - 1].rst = 1'b1;
    for (int i = 0; i < n - 1; i++) push_cyc(SIdle, 1'b0, 1'b1, 2'b00, 1'b1);
    push_any(SIdle, 2'b00);
  endtask

  task automatic add_halt(input logic [1:0] fc, input int hold);
    for (int i = 0; i < hold; i++) push_any(SHalt, fc);
    add_reset(1 + int'($urandom_range(0, 1)));
  endtask

  task automatic add_wait(input logic [3:0] st, input int lows, output bit timed_out);
    int n;
    n = (lows >= int'(WaitLimit)) ? int'(WaitLimit) : lows;
    for (int i = 0; i < n; i++) push_cyc(st, 1'b0, 1'b0, 2'b00, 1'b1);
    timed_out = (lows >= int'(WaitLimit));
    if (!timed_out) push_cyc(st, 1'b1, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic plan_instr(input logic [5:0] op, input int lows_f, input int lows_m);
    bit to;
    cur_op = op;
    add_wait(SFetch, lows_f, to);
    if (to) begin add_halt(2'b10, 3 + int'($urandom_range(0, 4))); return; end
    push_any(SDecode, 2'b00);
    case (op)
      OpR:    begin push_any(SExecute, 2'b00); push_any(SRwb, 2'b00); end
      OpAddi: begin push_any(SAddiEx, 2'b00); push_any(SAddiWb, 2'b00); end
      OpBeq:  push_any(SBranch, 2'b00);
      OpJ:    push_any(SJump, 2'b00);
      OpLw: begin
        push_any(SMemAddr, 2'b00);
        add_wait(SMemRead, lows_m, to);
        if (to) add_halt(2'b10, 3);
        else push_any(SMemWb, 2'b00);
      end
      OpSw: begin
        push_any(SMemAddr, 2'b00);
        add_wait(SMemWrite, lows_m, to);
        if (to) add_halt(2'b10, 3);
      end
      default: add_halt(2'b01, 20);
    endcase
  endtask

  function automatic int rand_lows();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return int'($urandom_range(1, 4));
    if (r == 8) return int'($urandom_range(13, 14));
    return int'(WaitLimit);
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] legal [6];
    logic [5:0] o;
    legal = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi};
    if ($urandom_range(0, 7) != 0) return legal[$urandom_range(0, 5)];
    do o = 6'($urandom); while (o inside {OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi});
    return o;
  endfunction

  // Monitor: one expected control word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [23:0] got;
    got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, fault, fault_code,
           state};
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        n_checks++;
        if (got !== e.v) begin
          n_fail++;
          $display("FAIL ctrl_word state%0d @%0t: got %h expected %h", e.st, $time, got, e.v);
        end
      end
    end else if (finish_req) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    bit to;
    cur_op = OpR;
    // Two reset cycles; state before the first reset edge is unknown.
    push_cyc(SIdle, 1'b0, 1'b1, 2'b00, 1'b0);
    push_cyc(SIdle, 1'b0, 1'b1, 2'b00, 1'b1);
    push_any(SIdle, 2'b00);
    plan_instr(OpR, 0, 0);
    plan_instr(OpLw, 0, 3);
    plan_instr(OpBeq, 0, 0);
    plan_instr(OpJ, 0, 0);
    plan_instr(OpSw, 0, 0);
    plan_instr(OpAddi, 0, 0);
    plan_instr(6'b111111, 0, 0);
    plan_instr(OpR, 14, 0);
    plan_instr(OpR, 15, 0);
    plan_instr(OpLw, 0, 14);
    plan_instr(OpSw, 1, 15);
    // Reset while stalled in the store wait.
    cur_op = OpSw;
    add_wait(SFetch, 0, to);
    push_any(SDecode, 2'b00);
    push_any(SMemAddr, 2'b00);
    push_cyc(SMemWrite, 1'b0, 1'b0, 2'b00, 1'b1);
    push_cyc(SMemWrite, 1'b0, 1'b0, 2'b00, 1'b1);
    add_reset(1);
    for (int k = 0; k < 80; k++) plan_instr(rand_op(), rand_lows(), rand_lows());

    foreach (plan[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      reset     = plan[i].rst;
      mem_ready = plan[i].rdy;
      opcode    = plan[i].op;
      e.chk = plan[i].chk;
      e.st  = plan[i].st;
      e.v   = exp_vec(plan[i].st, plan[i].rdy, plan[i].fc);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    finish_req = 1'b1;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main control unit for the MIPS-subset datapath.
- Walks each instruction through fetch, decode, execute, memory and writeback phases.
- Drives every datapath mux select (address source, ALU A/B source, PC source, write-register select, writeback-data select) plus the register and memory write enables.
- Sits directly upstream of the datapath mux network. It stalls on a memory-ready handshake and traps into a halt state on an illegal opcode or a memory timeout.

Parameters:
- WAIT_LIMIT, 15: consecutive mem_ready-low cycles tolerated in one wait state before a timeout halt.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  2  ALU control: 00 = add, 01 = sub, 10 = decode from funct.
- pc_source  out  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target (11 is aliased to 00 by the 3-input mux and is never driven).
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- fault  out  1  sticky halt indicator.
- fault_code  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none.
- state  out  4  current state encoding, for debug.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=15. Codes 13–14 are unused and recover to IDLE.
- Reset:
  - reset=1 at a clock edge forces state to IDLE and clears wait_cnt, fault and fault_code, regardless of the current state (including mid-wait and HALT).
  - In IDLE all outputs are 0.
  - IDLE always goes to FETCH on the next cycle.
- Output decoding: all outputs are decoded from the registered state. Any output not listed for a state is 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write = pc_write = mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADDR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMREAD: mem_read=1, i_or_d=1.
  - MEMWRITE: mem_write=1, i_or_d=1, instr_done=mem_ready.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - JUMP: pc_write=1, pc_source=10, instr_done=1.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - HALT: fault=1, fault_code held; every other output 0.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1, otherwise stays in FETCH.
  - DECODE dispatches on opcode: 000000 to EXECUTE; 100011 or 101011 to MEMADDR; 000100 to BRANCH; 000010 to JUMP; 001000 to ADDIEX. Any other opcode goes to HALT with fault_code=01.
  - MEMADDR goes to MEMREAD for lw and MEMWRITE for sw.
  - MEMREAD goes to MEMWB when mem_ready=1, otherwise waits.
  - MEMWRITE goes to FETCH when mem_ready=1, otherwise waits.
  - EXECUTE goes to RWB; ADDIEX goes to ADDIWB.
  - MEMWB, RWB, BRANCH, JUMP and ADDIWB each go to FETCH.
  - HALT stays in HALT until reset.
- Opcode sampling: opcode is sampled in DECODE and again in MEMADDR. It must be stable from DECODE through writeback.
- Wait counter (wait states are FETCH, MEMREAD, MEMWRITE):
  - wait_cnt clears on entry to any wait state and whenever mem_ready=1.
  - It increments by 1 each cycle spent in a wait state with mem_ready=0.
  - If mem_ready=0 on the WAIT_LIMIT-th consecutive low cycle (wait_cnt == WAIT_LIMIT-1), the next state is HALT with fault_code=10.
  - If mem_ready=1 in that same cycle, the state advances normally; the ready response wins over the timeout.
- Cycle counts with mem_ready tied high (including FETCH): R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.

Test Plan:
- Reset then R-type: reset high 2 cycles, opcode=000000, mem_ready=1 -> state sequence 0,1,2,7,8,1. RWB shows reg_write=1, reg_dst=1. instr_done pulses once.
- lw with memory stall: opcode=100011, mem_ready low for 3 cycles in MEMREAD -> MEMREAD held exactly 4 cycles with mem_read=1, i_or_d=1; then MEMWB with mem_to_reg=1; 8 cycles total from FETCH.
- beq and j: opcode=000100 -> BRANCH drives pc_write_cond=1, pc_source=01, alu_op=01. opcode=000010 -> JUMP drives pc_write=1, pc_source=10. Both return to FETCH.
- Illegal opcode: opcode=111111 in DECODE -> HALT, fault=1, fault_code=01, all write enables 0, held for 20 cycles; reset -> IDLE, fault=0.
- Timeout boundary: in FETCH, mem_ready=0 for 14 cycles then 1 -> DECODE, no fault. mem_ready=0 for 15 cycles -> HALT, fault_code=10.
- Reset mid-instruction: assert reset while in MEMWRITE with mem_ready=0 -> next cycle state=0, mem_write=0, wait_cnt=0.
